// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter family.
// Contents:
//   estado_t           - transmitter FSM states (OCIOSO..PARADA)
//   PARIDADE_*         - parity-mode codes used by the PARITY generic
//   paridade_ativa()   - true when a parity mode emits a parity bit
//   bit_paridade()     - parity bit for a payload of up to 9 bits
package serial_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARIDADE,
    PARADA
  } estado_t;

  localparam int PARIDADE_NENHUMA = 0;
  localparam int PARIDADE_PAR     = 1;
  localparam int PARIDADE_IMPAR   = 2;

  // Unknown mode codes fall back to "no parity".
  function automatic logic paridade_ativa(input int modo);
    return (modo == PARIDADE_PAR) || (modo == PARIDADE_IMPAR);
  endfunction

  // Payload is zero-extended to 9 bits; the extra zeros do not change the XOR.
  function automatic logic bit_paridade(input int modo, input logic [8:0] palavra);
    logic r;
    r = 1'b0;
    if (modo == PARIDADE_PAR) begin
      r = ^palavra;
    end else if (modo == PARIDADE_IMPAR) begin
      r = ~(^palavra);
    end
    return r;
  endfunction

endpackage

// File: rtl/gerador_tick_baud.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clock     in  system clock, rising edge
//   reset_n   in  asynchronous active-low reset
//   reiniciar in  synchronous restart: holds the count at 0, suppresses fim_bit
//   fim_bit   out high in the last cycle (count = CLKS_PER_BIT-1) of each bit period
module gerador_tick_baud #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clock,
  input  logic reset_n,
  input  logic reiniciar,
  output logic fim_bit
);

  localparam int            W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0]  ULTIMO = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] contador;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador <= '0;
    end else if (reiniciar || (contador == ULTIMO)) begin
      contador <= '0;
    end else begin
      contador <= contador + W'(1);
    end
  end

  assign fim_bit = !reiniciar && (contador == ULTIMO);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-word holding register.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   clock               in  system clock, rising edge
//   reset_n             in  asynchronous active-low reset
//   iniciar             in  valid; word accepted when iniciar && pronto
//   dados               in  payload, sampled on acceptance
//   pronto              out ready, high while the holding register is empty
//   saida_serial        out serial line, idle high, registered
//   transmissor_ocupado out high while a frame is on the line or a word is held
//   transmissor_acabou  out one-cycle pulse in the last cycle of the final stop bit
module uart_tx_param
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 iniciar,
  input  logic [DATA_BITS-1:0] dados,
  output logic                 pronto,
  output logic                 saida_serial,
  output logic                 transmissor_ocupado,
  output logic                 transmissor_acabou
);

  localparam logic             TEM_PARIDADE  = paridade_ativa(PARITY);
  localparam int               IW            = $clog2(DATA_BITS);
  localparam logic [IW-1:0]    ULTIMO_BIT    = IW'(DATA_BITS - 1);
  // Stop counter is a single bit: 0 for one stop bit, 1 marks the second.
  localparam logic             ULTIMA_PARADA = (STOP_BITS >= 2);

  estado_t                estado, estado_prox;
  logic                   cheio;
  logic [DATA_BITS-1:0]   retido;
  logic [DATA_BITS-1:0]   desloc, desloc_prox;
  logic [IW-1:0]          indice, indice_prox;
  logic                   cont_parada, cont_parada_prox;
  logic                   bit_par;
  logic                   linha_prox;
  logic                   carregar;
  logic                   aceitar;
  logic                   fim_bit;

  gerador_tick_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clock    (clock),
    .reset_n  (reset_n),
    .reiniciar(estado == OCIOSO),
    .fim_bit  (fim_bit)
  );

  assign pronto              = !cheio;
  assign aceitar             = iniciar && !cheio;
  assign transmissor_ocupado = (estado != OCIOSO) || cheio;

  // The line is registered from the next-state decision, so the value that
  // belongs to a state appears together with that state.
  always_comb begin
    estado_prox        = estado;
    desloc_prox        = desloc;
    indice_prox        = indice;
    cont_parada_prox   = cont_parada;
    linha_prox         = saida_serial;
    carregar           = 1'b0;
    transmissor_acabou = 1'b0;

    unique case (estado)
      OCIOSO: begin
        linha_prox = 1'b1;
        if (cheio) begin
          estado_prox = INICIO;
          carregar    = 1'b1;
          linha_prox  = 1'b0;
        end
      end

      INICIO: begin
        if (fim_bit) begin
          estado_prox = DADOS;
          linha_prox  = desloc[0];
        end
      end

      DADOS: begin
        if (fim_bit) begin
          if (indice == ULTIMO_BIT) begin
            if (TEM_PARIDADE) begin
              estado_prox = PARIDADE;
              linha_prox  = bit_par;
            end else begin
              estado_prox      = PARADA;
              cont_parada_prox = 1'b0;
              linha_prox       = 1'b1;
            end
          end else begin
            indice_prox = indice + IW'(1);
            desloc_prox = desloc >> 1;
            linha_prox  = desloc[1];
          end
        end
      end

      PARIDADE: begin
        if (fim_bit) begin
          estado_prox      = PARADA;
          cont_parada_prox = 1'b0;
          linha_prox       = 1'b1;
        end
      end

      PARADA: begin
        if (fim_bit) begin
          if (cont_parada == ULTIMA_PARADA) begin
            transmissor_acabou = 1'b1;
            if (cheio) begin
              estado_prox = INICIO;
              carregar    = 1'b1;
              linha_prox  = 1'b0;
            end else begin
              estado_prox = OCIOSO;
              linha_prox  = 1'b1;
            end
          end else begin
            cont_parada_prox = cont_parada + 1'b1;
            linha_prox       = 1'b1;
          end
        end
      end

      default: begin
        estado_prox = OCIOSO;
        linha_prox  = 1'b1;
      end
    endcase

    if (carregar) begin
      desloc_prox = retido;
      indice_prox = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= OCIOSO;
      desloc       <= '0;
      indice       <= '0;
      cont_parada  <= 1'b0;
      bit_par      <= 1'b0;
      saida_serial <= 1'b1;
      cheio        <= 1'b0;
      retido       <= '0;
    end else begin
      estado       <= estado_prox;
      desloc       <= desloc_prox;
      indice       <= indice_prox;
      cont_parada  <= cont_parada_prox;
      saida_serial <= linha_prox;
      if (carregar) begin
        bit_par <= bit_paridade(PARITY, 9'(retido));
      end
      // Acceptance wins over the transfer so a same-cycle refill keeps the
      // register full.
      if (aceitar) begin
        cheio  <= 1'b1;
        retido <= dados;
      end else if (carregar) begin
        cheio <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four instances with different
// generics, a frame-waveform reference model checked every cycle, a table of
// directed frames, hand-written corner sequences and random traffic.
module tb_uart_tx_param;

  localparam int unsigned NI = 4;
  localparam int unsigned CFG_C [NI] = '{4, 4, 3, 4};
  localparam int unsigned CFG_D [NI] = '{8, 7, 7, 8};
  localparam int unsigned CFG_P [NI] = '{0, 1, 2, 0};
  localparam int unsigned CFG_S [NI] = '{1, 2, 1, 2};

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic [NI-1:0] iniciar = '0;
  logic [8:0]    dados [NI];
  logic [NI-1:0] pronto, linha, ocupado, acabou;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clock(clk), .reset_n(reset_n), .iniciar(iniciar[0]), .dados(dados[0][7:0]),
    .pronto(pronto[0]), .saida_serial(linha[0]),
    .transmissor_ocupado(ocupado[0]), .transmissor_acabou(acabou[0]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
    .clock(clk), .reset_n(reset_n), .iniciar(iniciar[1]), .dados(dados[1][6:0]),
    .pronto(pronto[1]), .saida_serial(linha[1]),
    .transmissor_ocupado(ocupado[1]), .transmissor_acabou(acabou[1]));

  uart_tx_param #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u2 (
    .clock(clk), .reset_n(reset_n), .iniciar(iniciar[2]), .dados(dados[2][6:0]),
    .pronto(pronto[2]), .saida_serial(linha[2]),
    .transmissor_ocupado(ocupado[2]), .transmissor_acabou(acabou[2]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
    .clock(clk), .reset_n(reset_n), .iniciar(iniciar[3]), .dados(dados[3][7:0]),
    .pronto(pronto[3]), .saida_serial(linha[3]),
    .transmissor_ocupado(ocupado[3]), .transmissor_acabou(acabou[3]));

  task automatic chk1(input string name, input int unsigned inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d: got %b want %b at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int unsigned inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s u%0d: got %0d want %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  // ---------------- reference model: expected line waveform per instance ----
  logic [63:0] m_wave [NI];
  int          m_cnt  [NI];
  logic        m_held [NI];
  logic [8:0]  m_word [NI];

  task automatic build_frame(input int unsigned i, input logic [8:0] w,
                             output logic [63:0] wave, output int len);
    logic [15:0] bits;
    int unsigned nbits;
    int          ones;
    bits  = '0;
    nbits = 1;          // bits[0] = start bit 0
    ones  = 0;
    for (int unsigned k = 0; k < CFG_D[i]; k++) begin
      bits[nbits] = w[k];
      ones += int'(w[k]);
      nbits++;
    end
    if (CFG_P[i] == 1) begin
      bits[nbits] = (ones % 2 == 1);
      nbits++;
    end else if (CFG_P[i] == 2) begin
      bits[nbits] = (ones % 2 == 0);
      nbits++;
    end
    for (int unsigned s = 0; s < CFG_S[i]; s++) begin
      bits[nbits] = 1'b1;
      nbits++;
    end
    wave = '0;
    len  = 0;
    for (int unsigned k = 0; k < nbits; k++) begin
      for (int unsigned j = 0; j < CFG_C[i]; j++) begin
        wave[len] = bits[k];
        len++;
      end
    end
  endtask

  // Check the current cycle at the falling edge, then advance the model to
  // the cycle after the coming rising edge.
  initial begin
    for (int unsigned i = 0; i < NI; i++) begin
      m_wave[i] = '0; m_cnt[i] = 0; m_held[i] = 1'b0; m_word[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int unsigned i = 0; i < NI; i++) begin
        if (!reset_n) begin
          chk1("rst_line",    i, linha[i],   1'b1);
          chk1("rst_pronto",  i, pronto[i],  1'b1);
          chk1("rst_ocupado", i, ocupado[i], 1'b0);
          chk1("rst_acabou",  i, acabou[i],  1'b0);
          m_wave[i] = '0; m_cnt[i] = 0; m_held[i] = 1'b0;
        end else begin
          logic was_held;
          chk1("line",    i, linha[i],   (m_cnt[i] > 0) ? m_wave[i][0] : 1'b1);
          chk1("pronto",  i, pronto[i],  !m_held[i]);
          chk1("ocupado", i, ocupado[i], (m_cnt[i] > 0) || m_held[i]);
          chk1("acabou",  i, acabou[i],  m_cnt[i] == 1);
          was_held = m_held[i];
          if (m_cnt[i] > 0) begin
            m_wave[i] = m_wave[i] >> 1;
            m_cnt[i]--;
          end
          if (m_cnt[i] == 0 && was_held) begin
            build_frame(i, m_word[i], m_wave[i], m_cnt[i]);
            m_held[i] = 1'b0;
          end
          if (iniciar[i] && !was_held) begin
            m_held[i] = 1'b1;
            m_word[i] = dados[i];
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input int unsigned i, input logic [8:0] w);
    iniciar[i] = 1'b1;
    dados[i]   = w;
    tick();
    iniciar[i] = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned i);
    int n;
    n = 0;
    while ((ocupado[i] || !pronto[i]) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk1("idle_timeout", i, ocupado[i], 1'b0);
  endtask

  typedef struct {
    int unsigned inst;
    logic [8:0]  data;
    logic [15:0] bits;   // expected line per bit period, bits[0] = start bit
    int unsigned nbits;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int unsigned i, c, n, good, pulses, busy, low, prl;
    int pulse_at, cyc;
    logic eb;

    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
    // unreachable; keeps the block's variables in use for tools that complain
    i = 0; c = 0; n = 0; good = 0; pulses = 0; busy = 0; low = 0; prl = 0;
    pulse_at = 0; cyc = 0; eb = 1'b0;
  end

  initial begin
    int unsigned i, c, n, good, pulses, busy, low, prl;
    int pulse_at, cyc;
    logic eb;

    vecs[0] = '{inst: 0, data: 9'h055, bits: 16'h02AA, nbits: 10};
    vecs[1] = '{inst: 0, data: 9'h0FF, bits: 16'h03FE, nbits: 10};
    vecs[2] = '{inst: 0, data: 9'h000, bits: 16'h0200, nbits: 10};
    vecs[3] = '{inst: 1, data: 9'h007, bits: 16'h070E, nbits: 11};
    vecs[4] = '{inst: 1, data: 9'h003, bits: 16'h0606, nbits: 11};
    vecs[5] = '{inst: 2, data: 9'h007, bits: 16'h020E, nbits: 10};
    vecs[6] = '{inst: 2, data: 9'h003, bits: 16'h0306, nbits: 10};
    vecs[7] = '{inst: 3, data: 9'h0A3, bits: 16'h0746, nbits: 11};

    for (int unsigned k = 0; k < NI; k++) dados[k] = '0;

    // ---- reset state ----
    #1 reset_n = 1'b0;
    repeat (3) tick();
    for (int unsigned k = 0; k < NI; k++) begin
      chk1("reset_line",    k, linha[k],   1'b1);
      chk1("reset_pronto",  k, pronto[k],  1'b1);
      chk1("reset_ocupado", k, ocupado[k], 1'b0);
    end
    reset_n = 1'b1;
    tick();

    // ---- table of directed frames ----
    for (int unsigned v = 0; v < 8; v++) begin
      i = vecs[v].inst;
      c = CFG_C[i];
      wait_idle(i);
      send_word(i, vecs[v].data);
      chk1($sformatf("v%0d_lat_pronto", v), i, pronto[i], 1'b0);
      chk1($sformatf("v%0d_lat_line", v),   i, linha[i],  1'b1);
      tick();
      pulses = 0; pulse_at = -1; cyc = 0;
      for (int unsigned k = 0; k < vecs[v].nbits; k++) begin
        eb   = vecs[v].bits[k];
        good = 0;
        for (int unsigned j = 0; j < c; j++) begin
          if (linha[i] === eb) good++;
          if (acabou[i]) begin
            pulses++;
            pulse_at = cyc;
          end
          cyc++;
          tick();
        end
        chkn($sformatf("v%0d_bit%0d_cycles", v, k), i, int'(good), int'(c));
      end
      chkn($sformatf("v%0d_acabou_count", v), i, int'(pulses), 1);
      chkn($sformatf("v%0d_acabou_pos", v), i, pulse_at, int'(vecs[v].nbits * c) - 1);
      chk1($sformatf("v%0d_end_line", v),    i, linha[i],   1'b1);
      chk1($sformatf("v%0d_end_ocupado", v), i, ocupado[i], 1'b0);
    end

    // ---- back-to-back frames on u0 (40-cycle frames) ----
    wait_idle(0);
    send_word(0, 9'h012);
    tick();
    chk1("b2b_first_start", 0, linha[0],  1'b0);
    chk1("b2b_pronto_free", 0, pronto[0], 1'b1);
    send_word(0, 9'h034);
    chk1("b2b_pronto_low", 0, pronto[0], 1'b0);
    n = 0; prl = 0;
    while (!acabou[0] && n < 100) begin
      if (pronto[0]) prl++;
      tick();
      n++;
    end
    chkn("b2b_acabou_time", 0, int'(n), 38);
    chkn("b2b_pronto_held", 0, int'(prl), 0);
    tick();
    chk1("b2b_zero_gap",   0, linha[0],   1'b0);
    chk1("b2b_pronto_up",  0, pronto[0],  1'b1);
    chk1("b2b_still_busy", 0, ocupado[0], 1'b1);
    n = 0;
    while (!acabou[0] && n < 100) begin
      tick();
      n++;
    end
    chkn("b2b_second_end", 0, int'(n), 39);
    tick();
    chk1("b2b_idle", 0, ocupado[0], 1'b0);

    // ---- iniciar held high with changing dados on u3 ----
    wait_idle(3);
    iniciar[3] = 1'b1;
    for (int unsigned k = 0; k < 150; k++) begin
      dados[3] = 9'($urandom);
      tick();
    end
    iniciar[3] = 1'b0;
    wait_idle(3);

    // ---- reset in the middle of data bit 3 with a word held ----
    wait_idle(0);
    send_word(0, 9'h0A5);
    tick();
    send_word(0, 9'h05A);
    repeat (15) tick();
    chk1("mid_bit3_line", 0, linha[0], 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk1("async_line",    0, linha[0],   1'b1);
    chk1("async_pronto",  0, pronto[0],  1'b1);
    chk1("async_ocupado", 0, ocupado[0], 1'b0);
    chk1("async_acabou",  0, acabou[0],  1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    pulses = 0; busy = 0; low = 0;
    for (int unsigned k = 0; k < 120; k++) begin
      tick();
      if (acabou[0])  pulses++;
      if (ocupado[0]) busy++;
      if (!linha[0])  low++;
    end
    chkn("post_rst_acabou",  0, int'(pulses), 0);
    chkn("post_rst_ocupado", 0, int'(busy),   0);
    chkn("post_rst_line_lo", 0, int'(low),    0);

    // ---- random traffic: sparse, then dense (many ignored requests) ----
    for (int unsigned ph = 0; ph < 2; ph++) begin
      for (int unsigned k = 0; k < 1500; k++) begin
        for (int unsigned q = 0; q < NI; q++) begin
          iniciar[q] = (ph == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
          dados[q]   = 9'($urandom);
        end
        tick();
      end
    end
    iniciar = '0;
    for (int unsigned q = 0; q < NI; q++) wait_idle(q);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
